// File: rtl/fetch_if.sv
// Controller-facing strobes, fetched instruction and byte-wide program load port of fetch_unit.
interface fetch_if #(
    parameter int ADDR_W = 6
);
    logic              w_IR;
    logic              w_pc;
    logic              M3;
    logic [ADDR_W-1:0] gamma;
    logic              q;
    logic [20:0]       instruction;
    logic [ADDR_W-1:0] pc;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic              ld_ready;
    logic              run;
    logic              halted;

    modport master (
        output w_IR, w_pc, M3, gamma, q, ld_valid, ld_byte, ld_last,
        input  instruction, pc, ld_ready, run, halted
    );

    modport slave (
        input  w_IR, w_pc, M3, gamma, q, ld_valid, ld_byte, ld_last,
        output instruction, pc, ld_ready, run, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Program memory, PC and instruction register with a LOAD/RUN/HALT sequencer.
// Define FETCH_RELOAD_EN to let a halted unit accept a fresh program load.
module fetch_unit #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic    clk,
    input  logic    rst_n,
    fetch_if.slave  bus
);
    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [20:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [15:0]       word_lo_q, word_lo_d;
    logic              run_q, run_d;
    logic              halted_q, halted_d;
    logic [20:0]       mem_q [DEPTH];

    logic              mem_we;
    logic [20:0]       mem_wdata;
    logic              ld_ready;
    logic              xfer;

`ifdef FETCH_RELOAD_EN
    assign ld_ready = (state_q == S_LOAD) || (state_q == S_HALT);
`else
    assign ld_ready = (state_q == S_LOAD);
`endif
    assign xfer      = bus.ld_valid && ld_ready;
    assign mem_wdata = {bus.ld_byte[4:0], word_lo_q};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        load_addr_d = load_addr_q;
        byte_idx_d  = byte_idx_q;
        word_lo_d   = word_lo_q;
        mem_we      = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (xfer) begin
                    case (byte_idx_q)
                        2'd1: begin
                            word_lo_d[15:8] = bus.ld_byte;
                            byte_idx_d      = 2'd2;
                        end
                        2'd2: begin
                            mem_we      = 1'b1;
                            load_addr_d = load_addr_q + ADDR_W'(1);
                            byte_idx_d  = 2'd0;
                            // A full memory ends the load just like an explicit last marker.
                            if (bus.ld_last || load_addr_q == ADDR_W'(DEPTH - 1)) begin
                                state_d = S_RUN;
                                pc_d    = '0;
                            end
                        end
                        default: begin
                            word_lo_d[7:0] = bus.ld_byte;
                            byte_idx_d     = 2'd1;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (bus.w_IR)
                    ir_d = mem_q[pc_q];
                // Terminate wins over a PC update; the IR fetch still happens.
                if (bus.q)
                    state_d = S_HALT;
                else if (bus.w_pc)
                    pc_d = bus.M3 ? pc_q + ADDR_W'(1) : bus.gamma;
            end
            S_HALT: begin
`ifdef FETCH_RELOAD_EN
                if (xfer) begin
                    state_d        = S_LOAD;
                    load_addr_d    = '0;
                    word_lo_d[7:0] = bus.ld_byte;
                    byte_idx_d     = 2'd1;
                end
`endif
            end
            default: state_d = S_LOAD;
        endcase
        run_d    = (state_d == S_RUN);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            pc_q        <= '0;
            ir_q        <= '0;
            load_addr_q <= '0;
            byte_idx_q  <= '0;
            word_lo_q   <= '0;
            run_q       <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            load_addr_q <= load_addr_d;
            byte_idx_q  <= byte_idx_d;
            word_lo_q   <= word_lo_d;
            run_q       <= run_d;
            halted_q    <= halted_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[load_addr_q] <= mem_wdata;
        end
    end

    assign bus.instruction = ir_q;
    assign bus.pc          = pc_q;
    assign bus.ld_ready    = ld_ready;
    assign bus.run         = run_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: load, fetch/jump, halt priority, mid-load reset, full-memory load.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    fetch_if #(.ADDR_W(6)) bus ();

    fetch_unit #(.ADDR_W(6), .DEPTH(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    // Upper three bits of the third byte are set to 1 to show they are dropped.
    task automatic send_word(input logic [20:0] w, input logic last);
        send(w[7:0], 1'b0);
        send(w[15:8], 1'b0);
        send({3'b111, w[20:16]}, last);
    endtask

    function automatic logic [20:0] fill_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b[4:0] ^ 5'h15, b + 8'h80, ~b};
    endfunction

    initial begin
        rst_n        = 1'b1;
        bus.w_IR     = 1'b0;
        bus.w_pc     = 1'b0;
        bus.M3       = 1'b0;
        bus.gamma    = '0;
        bus.q        = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = '0;
        bus.ld_last  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc",       32'(bus.pc), 0);
        chk("rst_ir",       32'(bus.instruction), 0);
        chk("rst_run",      32'(bus.run), 0);
        chk("rst_halted",   32'(bus.halted), 0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Three-word load with a valid gap mid-word and ld_last asserted early (ignored).
        send_word(21'h0A5123, 1'b0);
        send(8'h45, 1'b1);
        tick();
        send(8'h23, 1'b1);
        send(8'hE1, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        chk("load_run_before_last", 32'(bus.run), 0);
        chk("load_ready_before_last", 32'(bus.ld_ready), 1);
        send(8'h1F, 1'b1);
        chk("load_run_after_last", 32'(bus.run), 1);
        chk("load_ready_after_last", 32'(bus.ld_ready), 0);
        chk("load_pc_after_last", 32'(bus.pc), 0);

        // Sequential fetch of the three words.
        bus.w_IR = 1'b1; tick(); bus.w_IR = 1'b0;
        chk("fetch0_ir", 32'(bus.instruction), 32'h0A5123);
        bus.w_pc = 1'b1; bus.M3 = 1'b1; tick(); bus.w_pc = 1'b0;
        chk("fetch0_pc", 32'(bus.pc), 1);
        bus.w_IR = 1'b1; tick(); bus.w_IR = 1'b0;
        chk("fetch1_ir", 32'(bus.instruction), 32'h012345);
        bus.w_pc = 1'b1; tick(); bus.w_pc = 1'b0;
        chk("fetch1_pc", 32'(bus.pc), 2);
        bus.w_IR = 1'b1; tick(); bus.w_IR = 1'b0;
        chk("fetch2_ir", 32'(bus.instruction), 32'h1FFFFF);
        bus.w_pc = 1'b1; tick(); bus.w_pc = 1'b0;
        chk("fetch2_pc", 32'(bus.pc), 3);

        // IR and PC together: IR takes mem[3] (never loaded, so 0), PC moves to 4.
        bus.w_IR = 1'b1; bus.w_pc = 1'b1; tick();
        bus.w_IR = 1'b0; bus.w_pc = 1'b0;
        chk("both_ir", 32'(bus.instruction), 0);
        chk("both_pc", 32'(bus.pc), 4);

        // Jump then increment across the wrap.
        bus.w_pc = 1'b1; bus.M3 = 1'b0; bus.gamma = 6'h3E; tick();
        chk("jump_pc", 32'(bus.pc), 32'h3E);
        bus.M3 = 1'b1; tick();
        chk("inc_pc_3f", 32'(bus.pc), 32'h3F);
        tick();
        bus.w_pc = 1'b0;
        chk("wrap_pc", 32'(bus.pc), 0);
        bus.w_IR = 1'b1; tick(); bus.w_IR = 1'b0;
        chk("wrap_ir", 32'(bus.instruction), 32'h0A5123);

        // Halt: q beats a same-cycle w_pc; afterwards strobes and load bytes are ignored.
        bus.w_pc = 1'b1; bus.M3 = 1'b0; bus.gamma = 6'd5; tick();
        chk("halt_setup_pc", 32'(bus.pc), 5);
        bus.M3 = 1'b1; bus.q = 1'b1; tick();
        bus.q = 1'b0; bus.w_pc = 1'b0;
        chk("halt_halted", 32'(bus.halted), 1);
        chk("halt_run", 32'(bus.run), 0);
        chk("halt_pc", 32'(bus.pc), 5);
        chk("halt_ld_ready", 32'(bus.ld_ready), 0);
        bus.w_IR = 1'b1; bus.w_pc = 1'b1; bus.M3 = 1'b1; tick();
        bus.w_IR = 1'b0; bus.w_pc = 1'b0;
        chk("halt_frozen_pc", 32'(bus.pc), 5);
        chk("halt_frozen_ir", 32'(bus.instruction), 32'h0A5123);
        send(8'h77, 1'b0);
        chk("halt_still_halted", 32'(bus.halted), 1);

        // Reset in the middle of a two-word load (4 of 6 bytes sent).
        rst_n = 1'b0; #1; tick(); rst_n = 1'b1; tick();
        send(8'h11, 1'b0);
        send(8'h01, 1'b0);
        bus.w_IR = 1'b1; bus.w_pc = 1'b1;
        send(8'h00, 1'b0);
        bus.w_IR = 1'b0; bus.w_pc = 1'b0;
        chk("load_ignores_strobes_pc", 32'(bus.pc), 0);
        chk("load_ignores_strobes_ir", 32'(bus.instruction), 0);
        send(8'h22, 1'b0);
        rst_n = 1'b0; #1;
        chk("midrst_ld_ready", 32'(bus.ld_ready), 1);
        chk("midrst_run", 32'(bus.run), 0);
        chk("midrst_halted", 32'(bus.halted), 0);
        chk("midrst_mem0", 32'(u_dut.mem_q[0]), 0);
        tick(); rst_n = 1'b1; tick();
        send_word(21'h000333, 1'b0);
        send_word(21'h000444, 1'b1);
        chk("reload_run", 32'(bus.run), 1);
        bus.w_IR = 1'b1; tick(); bus.w_IR = 1'b0;
        chk("reload_ir0", 32'(bus.instruction), 32'h000333);
        bus.w_pc = 1'b1; bus.M3 = 1'b1; tick(); bus.w_pc = 1'b0;
        bus.w_IR = 1'b1; tick(); bus.w_IR = 1'b0;
        chk("reload_ir1", 32'(bus.instruction), 32'h000444);

        // Full memory without ld_last: RUN starts after the 192nd byte.
        rst_n = 1'b0; #1; tick(); rst_n = 1'b1; tick();
        for (int i = 0; i < 63; i++)
            send_word(fill_word(i), 1'b0);
        send(fill_word(63) & 8'hFF, 1'b0);
        send(fill_word(63) >> 8, 1'b0);
        chk("full_run_before", 32'(bus.run), 0);
        send({3'b000, fill_word(63) >> 16}, 1'b0);
        chk("full_run_after", 32'(bus.run), 1);
        chk("full_ld_ready", 32'(bus.ld_ready), 0);
        chk("full_pc", 32'(bus.pc), 0);
        bus.w_IR = 1'b1; tick(); bus.w_IR = 1'b0;
        chk("full_ir0", 32'(bus.instruction), 32'(fill_word(0)));
        bus.w_pc = 1'b1; bus.M3 = 1'b0; bus.gamma = 6'd63; tick(); bus.w_pc = 1'b0;
        bus.w_IR = 1'b1; tick(); bus.w_IR = 1'b0;
        chk("full_ir63", 32'(bus.instruction), 32'(fill_word(63)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-supply end of the control-unit interface. Holds program memory, the program counter and the instruction register. It answers the controller's `w_IR`, `w_pc`, `M3`, `gamma` and `q` strobes, and drives the 21-bit `instruction` word back to it. Before execution, a byte-wide valid/ready load port fills program memory.

## Interface
Parameters:
- `ADDR_W`, 6: PC and memory address width; matches the width of the `gamma` jump target.
- `DEPTH`, 64: number of program words; must equal 2**ADDR_W.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `w_IR`  in  1  load the instruction register from mem[pc].
- `w_pc`  in  1  update the PC.
- `M3`  in  1  PC source select: 1 = pc+1, 0 = `gamma`.
- `gamma`  in  ADDR_W  jump target.
- `q`  in  1  terminate request from the controller.
- `instruction`  out  21  instruction register contents.
- `pc`  out  ADDR_W  current program counter.
- `ld_valid`  in  1  load byte valid.
- `ld_byte`  in  8  load data.
- `ld_last`  in  1  marks the final word; sampled only on the third byte of a word.
- `ld_ready`  out  1  load port ready.
- `run`  out  1  program loaded and not halted.
- `halted`  out  1  a terminate request has been taken.

## Operation
- Top-level FSM states: LOAD, RUN, HALT. Reset enters LOAD.
- Reset values:
  - `pc` = 0, `instruction` = 0, `run` = 0, `halted` = 0, `ld_ready` = 1.
  - Load address = 0, byte index = 0.
  - All memory words = 0. Opcode 0000 is a no-op to the controller.
- LOAD state:
  - `ld_ready` = 1. A byte transfers on a rising edge with `ld_valid` and `ld_ready` both high.
  - Byte index 0 sets word[7:0]; index 1 sets word[15:8]; index 2 sets word[20:16] from `ld_byte[4:0]`. `ld_byte[7:5]` on index 2 is ignored.
  - On index 2: mem[load_addr] is written with the assembled word, load_addr increments and the byte index returns to 0.
  - The LOAD→RUN transition happens on an index-2 transfer when either `ld_last` = 1 or load_addr = DEPTH-1 (memory full). On that transition: `pc` = 0, `run` = 1.
- RUN state:
  - `ld_ready` = 0.
  - `w_IR`: `instruction` <= mem[pc].
  - `w_pc`: `pc` <= M3 ? pc+1 (mod DEPTH, DEPTH-1 wraps to 0) : `gamma`.
  - `w_IR` and `w_pc` together: IR loads mem[old pc] and the PC updates in the same edge.
  - `q` = 1: go to HALT. This takes priority over a same-cycle `w_pc` (the PC does not change); a same-cycle `w_IR` is still honoured.
- HALT state:
  - `pc` and `instruction` are frozen; `w_IR` and `w_pc` are ignored.
  - `run` = 0, `halted` = 1, `ld_ready` = 0.
  - Exit is by reset only, unless the macro in Configuration is defined.
- `w_IR`, `w_pc` and `q` are ignored in LOAD.

## Timing
- Every output except `ld_ready` is registered. `ld_ready` is a decode of the FSM state.
- `w_IR` high at edge N: the new `instruction` is visible after edge N (1-cycle latency).
- `w_pc` high at edge N: the new `pc` is visible after edge N, so a `w_IR` at edge N+1 fetches from the new address.
- Loading takes 3 accepted transfers per word. `ld_valid` may drop between bytes; the partial word is held indefinitely.
- The last byte accepted at edge N gives `run` = 1 after N; the first `w_IR` can be honoured at edge N+1.
- Reset asserted mid-load or mid-run: all state returns to reset values immediately. Memory is cleared and partial words are discarded.

## Configuration
- `FETCH_RELOAD_EN`:
  - Defined: in HALT, `ld_ready` = 1. The first accepted byte moves the FSM to LOAD, clears `halted`, sets load_addr = 0 and is taken as byte index 0. Previously loaded words are kept unless overwritten.
  - Not defined: HALT is terminal until `rst_n` is asserted.

## Test plan
- Load 3 words (0x0A5123, 0x12345, 0x1FFFFF; ld_last on the third) -> mem[0..2] hold these words; `run` rises one edge after the 9th byte; `pc` = 0.
- RUN: `w_IR`, then `w_pc` with `M3`=1, repeated 3 times -> `instruction` = 0x0A5123, 0x012345, 0x1FFFFF in turn; `pc` ends at 3.
- `w_pc` with `M3`=0, `gamma`=0x3E, then `w_pc` with `M3`=1 twice -> `pc` = 0x3E, 0x3F, 0x00 (wrap).
- Load 64 words without `ld_last` -> `run` rises after the 192nd byte; `ld_ready` = 0 afterwards.
- `q` together with `w_pc` (`M3`=1) at `pc`=5 -> `halted` = 1, `pc` stays 5; later `w_IR`/`w_pc` have no effect.
- Assert `rst_n` low after 4 of 6 bytes of a two-word load -> `ld_ready` = 1, `run` = 0, mem[0] = 0; a fresh load starts at address 0.
